// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Y86-64 pipeline stall/bubble control with run/drain/halt FSM (optional counters: PIPE_CTRL_PERF_EN)
module pipe_hazard_ctrl #(
  parameter int          CNT_W = 32,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [3:0]  M_icode,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        halted,
  output logic [2:0]  halt_stat
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispred_cnt
`endif
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [2:0] S_AOK    = 3'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] halt_stat_q;

  logic load_use;
  logic ret_in;
  logic mispred;
  logic m_exc;
  logic w_exc;

  // Hazard terms decoded straight from the pipeline registers and stage outputs
  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_in   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred  = (E_icode == I_JXX) && !e_Cnd;
    m_exc    = (m_stat != S_AOK);
    w_exc    = (W_stat != S_AOK);
  end

  // Next state: an exception reaching W halts; one in M drains until it reaches W or is squashed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (w_exc)      state_d = ST_HALTED;
        else if (m_exc) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_exc)       state_d = ST_HALTED;
        else if (!m_exc) state_d = ST_RUN;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // Control word for the current cycle; reset flushes, HALTED freezes the whole core
  always_comb begin
    F_stall  = load_use | ret_in;
    D_stall  = load_use;
    D_bubble = mispred | (ret_in & ~load_use);
    E_bubble = mispred | load_use | m_exc | w_exc;
    M_bubble = m_exc | w_exc;
    W_stall  = w_exc;
    halted   = 1'b0;
    halt_stat = halt_stat_q;
    if (rst) begin
      F_stall   = 1'b0;
      D_stall   = 1'b0;
      D_bubble  = 1'b1;
      E_bubble  = 1'b1;
      M_bubble  = 1'b1;
      W_stall   = 1'b0;
      halt_stat = S_AOK;
    end else begin
      case (state_q)
        ST_DRAIN: M_bubble = 1'b1;
        ST_HALTED: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          D_bubble = 1'b0;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
          halted   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register; halt status captured only on the edge that enters HALTED
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      halt_stat_q <= S_AOK;
    end else begin
      state_q <= state_d;
      if ((state_q != ST_HALTED) && (state_d == ST_HALTED))
        halt_stat_q <= W_stat;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic active;
  assign active = (state_q != ST_HALTED);

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (active && cyc_cnt != CNT_MAX)
        cyc_cnt <= cyc_cnt + CNT_ONE;
      if (active && F_stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (active && (D_bubble || E_bubble) && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_ONE;
      if (mispred && mispred_cnt != CNT_MAX)
        mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end
`endif

  d_excl_a: assert property (@(posedge clk) !(D_stall && D_bubble));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized model-checked bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [2:0] halt_stat;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, bubble_cnt, mispred_cnt;
`endif

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .halt_stat(halt_stat)
`ifdef PIPE_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 = running, 1 = draining, 2 = halted
  int mode      = 0;
  int saved_st  = 1;
  int m_cyc = 0, m_stall = 0, m_bub = 0, m_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [5:0] exp_ctrl();
    bit lu, ri, mp, me, we;
    bit fs, ds, db, eb, mb, ws;
    lu = (E_icode == 5 || E_icode == 11) && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
    ri = (D_icode == 9) || (E_icode == 9) || (M_icode == 9);
    mp = (E_icode == 7) && !e_Cnd;
    me = (m_stat != 1);
    we = (W_stat != 1);
    if (rst) return 6'b001110;
    if (mode == 2) return 6'b110111;
    fs = lu || ri;
    ds = lu;
    db = mp || (ri && !lu);
    eb = mp || lu || me || we;
    mb = me || we || (mode == 1);
    ws = we;
    return {fs, ds, db, eb, mb, ws};
  endfunction

  task automatic quiet();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    e_Cnd = 1'b0; m_stat = 3'd1; W_stat = 3'd1; rst = 1'b0;
  endtask

  // check the current inputs against the model, then advance one clock
  task automatic cyc(input string tag);
    logic [5:0] ec;
    bit mp;
    @(negedge clk);
    ec = exp_ctrl();
    mp = (E_icode == 7) && !e_Cnd;
    check({tag, ".ctrl"}, {26'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, {26'd0, ec});
    check({tag, ".halted"}, {31'd0, halted}, (!rst && mode == 2) ? 32'd1 : 32'd0);
    check({tag, ".halt_stat"}, {29'd0, halt_stat}, rst ? 32'd1 : saved_st);
`ifdef PIPE_CTRL_PERF_EN
    check({tag, ".cyc_cnt"}, {28'd0, cyc_cnt}, m_cyc);
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, m_stall);
    check({tag, ".bubble_cnt"}, {28'd0, bubble_cnt}, m_bub);
    check({tag, ".mispred_cnt"}, {28'd0, mispred_cnt}, m_mis);
`endif
    @(posedge clk);
    if (rst) begin
      mode = 0; saved_st = 1;
      m_cyc = 0; m_stall = 0; m_bub = 0; m_mis = 0;
    end else begin
      if (mode != 2) begin
        m_cyc = sat(m_cyc);
        if (ec[5]) m_stall = sat(m_stall);
        if (ec[3] || ec[2]) m_bub = sat(m_bub);
      end
      if (mp) m_mis = sat(m_mis);
      if (mode != 2) begin
        if (W_stat != 1) begin mode = 2; saved_st = W_stat; end
        else if (mode == 0 && m_stat != 1) mode = 1;
        else if (mode == 1 && m_stat == 1) mode = 0;
      end
    end
    #1;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    cyc("reset0");
    cyc("reset1");
    rst = 1'b0;

    // load-use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    cyc("load_use");
    quiet();
    cyc("after_lu");

    // ret walking through D, E, M
    D_icode = 4'h9; cyc("ret_D");
    D_icode = 4'h1; E_icode = 4'h9; cyc("ret_E");
    E_icode = 4'h1; M_icode = 4'h9; cyc("ret_M");
    M_icode = 4'h1; cyc("ret_gone");
    check("ret_gone.F_stall", {31'd0, F_stall}, 32'd0);

    // mispredicted and correctly predicted jXX
    E_icode = 4'h7; e_Cnd = 1'b0; cyc("mispred");
    e_Cnd = 1'b1; cyc("taken");
    quiet();
    E_icode = 4'h7; cyc("mispred2");
    quiet();

    // load-use combined with ret in D
    E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; D_icode = 4'h9;
    cyc("lu_ret");
    quiet();

    // RNONE never forms a hazard
    E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; cyc("rnone");
    quiet();

    // exception drain then halt
    m_stat = 3'd3; cyc("exc_m");
    m_stat = 3'd1; W_stat = 3'd3; cyc("exc_drain");
    W_stat = 3'd1; cyc("halt0");
    check("halt.halted", {31'd0, halted}, 32'd1);
    check("halt.halt_stat", {29'd0, halt_stat}, 32'd3);
    W_stat = 3'd2; E_icode = 4'h7; cyc("halt1");
    quiet();
    rst = 1'b1; cyc("halt_rst");
    rst = 1'b0; cyc("post_rst");
    check("post_rst.halted", {31'd0, halted}, 32'd0);

    // drain squashed back to run
    m_stat = 3'd4; cyc("sq0");
    m_stat = 3'd1; cyc("sq1");
    cyc("sq2");

    // long quiet run saturates cyc_cnt
    for (int i = 0; i < 20; i++) cyc("quiet_run");
`ifdef PIPE_CTRL_PERF_EN
    check("cyc_sat", {28'd0, cyc_cnt}, CMAX);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] hot [6];
      hot[0] = 4'h5; hot[1] = 4'hB; hot[2] = 4'h7; hot[3] = 4'h9; hot[4] = 4'h1; hot[5] = 4'h6;
      rst     = ($urandom_range(0, 29) == 0);
      D_icode = ($urandom_range(0, 1) != 0) ? hot[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      E_icode = ($urandom_range(0, 1) != 0) ? hot[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      M_icode = ($urandom_range(0, 1) != 0) ? hot[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
